// File: rtl/tdc_pkg.sv
// Shared types and width helpers for the TDC measurement controller.
package tdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_CAPTURE,
        ST_ENCODE,
        ST_DONE,
        ST_RECOVER
    } tdc_state_t;

    // Width needed to express every count from 0 up to n inclusive.
    function automatic int code_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tdc_ctrl_if.sv
// Bus bundle between the TDC controller, its delay line and the result consumer.
interface tdc_ctrl_if
    import tdc_pkg::*;
#(
    parameter int N = 64
);
    localparam int W = code_width(N);

    logic         start;
    logic         launch;
    logic [N-1:0] dl_out;
    logic         busy;
    logic         valid;
    logic         ready;
    logic [W-1:0] code;
    logic         ovf;
    logic         bubble;

    modport master (
        input  start, dl_out, ready,
        output launch, busy, valid, code, ovf, bubble
    );

    modport slave (
        output start, dl_out, ready,
        input  launch, busy, valid, code, ovf, bubble
    );

endinterface

// File: rtl/tdc_therm_enc.sv
// Thermometer-to-binary encoder: lowest-zero index, overflow and bubble flags.
module tdc_therm_enc
    import tdc_pkg::*;
#(
    parameter  int N = 64,
    localparam int W = code_width(N)
) (
    input  logic [N-1:0] therm,
    output logic [W-1:0] code,
    output logic         ovf,
    output logic         bubble
);

    logic found;

    // The code always follows the first zero; any one above it is only flagged.
    always_comb begin
        code   = '0;
        ovf    = 1'b0;
        bubble = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (found) begin
                if (therm[i]) begin
                    bubble = 1'b1;
                end
            end else if (!therm[i]) begin
                found = 1'b1;
                code  = W'(i);
            end
        end
        if (!found) begin
            ovf  = 1'b1;
            code = W'(N);
        end
    end

endmodule

// File: rtl/tdc_ctrl.sv
// TDC measurement sequencer: fires the delay line, double-samples the taps,
// encodes the result and holds it until the consumer takes it.
module tdc_ctrl
    import tdc_pkg::*;
#(
    parameter int N       = 64,
    parameter int RECOVER = 4
) (
    input logic       clk,
    input logic       rst_n,
    tdc_ctrl_if.master bus
);

    localparam int W  = code_width(N);
    localparam int RW = $clog2(RECOVER + 1);
    localparam logic [RW-1:0] REC_LAST = RW'(RECOVER - 1);

    tdc_state_t   state, state_d;
    logic [RW-1:0] rec_cnt, rec_cnt_d;
    logic         launch_q;
    logic         valid_q;
    logic [W-1:0] code_q;
    logic         ovf_q;
    logic         bubble_q;
    logic [W-1:0] enc_code;
    logic         enc_ovf;
    logic         enc_bubble;

    (* keep = "true" *) logic [N-1:0] stage1;
    (* keep = "true" *) logic [N-1:0] stage2;

    always_comb begin
        state_d   = state;
        rec_cnt_d = rec_cnt;
        case (state)
            ST_IDLE:    if (bus.start) state_d = ST_LAUNCH;
            ST_LAUNCH:  state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_ENCODE;
            ST_ENCODE:  state_d = ST_DONE;
            ST_DONE: begin
                if (valid_q && bus.ready) begin
                    state_d   = ST_RECOVER;
                    rec_cnt_d = '0;
                end
            end
            ST_RECOVER: begin
                if (rec_cnt == REC_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    rec_cnt_d = rec_cnt + 1'b1;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // launch and valid are registered from the next state so they line up
    // exactly with the LAUNCH/CAPTURE and DONE windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rec_cnt  <= '0;
            launch_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_d;
            rec_cnt  <= rec_cnt_d;
            launch_q <= (state_d == ST_LAUNCH) || (state_d == ST_CAPTURE);
            valid_q  <= (state_d == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1   <= '0;
            stage2   <= '0;
            code_q   <= '0;
            ovf_q    <= 1'b0;
            bubble_q <= 1'b0;
        end else begin
            if (state == ST_LAUNCH) begin
                stage1 <= bus.dl_out;
            end
            if (state == ST_CAPTURE) begin
                stage2 <= stage1;
            end
            if (state == ST_ENCODE) begin
                code_q   <= enc_code;
                ovf_q    <= enc_ovf;
                bubble_q <= enc_bubble;
            end
        end
    end

    tdc_therm_enc #(.N(N)) u_enc (
        .therm  (stage2),
        .code   (enc_code),
        .ovf    (enc_ovf),
        .bubble (enc_bubble)
    );

    assign bus.launch = launch_q;
    assign bus.busy   = (state != ST_IDLE);
    assign bus.valid  = valid_q;
    assign bus.code   = code_q;
    assign bus.ovf    = ovf_q;
    assign bus.bubble = bubble_q;

endmodule

// File: tb/tb_tdc_ctrl.sv
// Self-checking bench for tdc_ctrl: timeline model compared every cycle,
// plus directed measurements with hand-computed codes.
module tb_tdc_ctrl;

    localparam int N       = 64;
    localparam int RECOVER = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   cmp_en   = 1'b0;

    tdc_ctrl_if #(.N(N)) bus ();

    tdc_ctrl #(.N(N), .RECOVER(RECOVER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [N-1:0] dl, input logic rdy);
        bus.start  = st;
        bus.dl_out = dl;
        bus.ready  = rdy;
    endtask

    // Reference encoding straight from the rules: walk up while ones, then any leftover one is a bubble.
    function automatic void model_enc(input logic [N-1:0] dl, output int c, output bit o, output bit b);
        c = 0;
        while (c < N && dl[c]) c++;
        o = (c == N);
        b = (c < N) && ((dl >> c) != '0);
    endfunction

    // Timeline model: edge index of acceptance, handshake-driven recovery end.
    int          e       = 0;
    int          t_acc   = 0;
    int          rec_end = -1;
    bit          m_active = 1'b0;
    logic [N-1:0] m_cap  = '0;
    int          m_code  = 0;
    bit          m_ovf   = 1'b0;
    bit          m_bub   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            rec_end  = -1;
            m_code   = 0;
            m_ovf    = 1'b0;
            m_bub    = 1'b0;
        end else begin
            e++;
            if (m_active) begin
                if (e == t_acc + 1) m_cap = bus.dl_out;
                if (e == t_acc + 3) model_enc(m_cap, m_code, m_ovf, m_bub);
                if (e >= t_acc + 4 && bus.ready) begin
                    m_active = 1'b0;
                    rec_end  = e + RECOVER;
                end
            end else if (e > rec_end && bus.start) begin
                m_active = 1'b1;
                t_acc    = e;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("cyc_launch", bus.launch, (rst_n && m_active && (e - t_acc) <= 1) ? 1 : 0);
            checkOutput("cyc_valid",  bus.valid,  (rst_n && m_active && (e - t_acc) >= 3) ? 1 : 0);
            checkOutput("cyc_busy",   bus.busy,   (rst_n && (m_active || e < rec_end)) ? 1 : 0);
            checkOutput("cyc_code",   bus.code,   m_code);
            checkOutput("cyc_ovf",    bus.ovf,    m_ovf);
            checkOutput("cyc_bubble", bus.bubble, m_bub);
        end
    end

    task automatic waitValid(input string name, output int k);
        k = 1;
        while (!bus.valid && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 3) checkOutput({name, "_launch_fall"}, bus.launch, 0);
        end
        checkOutput({name, "_latency"}, k, 4);
    endtask

    task automatic measure(input string name, input logic [N-1:0] dl, input int ec, input bit eo, input bit eb);
        int k;
        applyStimulus(1'b1, dl, 1'b0);
        @(negedge clk);
        checkOutput({name, "_launch_rise"}, bus.launch, 1);
        applyStimulus(1'b0, dl, 1'b0);
        waitValid(name, k);
        checkOutput({name, "_code"}, bus.code, ec);
        checkOutput({name, "_ovf"}, bus.ovf, eo);
        checkOutput({name, "_bubble"}, bus.bubble, eb);
        applyStimulus(1'b0, dl, 1'b1);
        @(negedge clk);
        checkOutput({name, "_valid_drop"}, bus.valid, 0);
        checkOutput({name, "_code_hold"}, bus.code, ec);
        applyStimulus(1'b0, dl, 1'b0);
        repeat (RECOVER) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        bit o, b;
        int k;

        rst_n = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);

        model_enc(64'h0000_0000_0000_FFFF, c, o, b);
        checkOutput("model_ffff_code", c, 16);
        model_enc(64'h0000_0000_0000_00EF, c, o, b);
        checkOutput("model_ef_code", c, 4);
        checkOutput("model_ef_bubble", b, 1);
        model_enc('1, c, o, b);
        checkOutput("model_ones_code", c, 64);
        checkOutput("model_ones_ovf", o, 1);

        repeat (3) @(negedge clk);
        checkOutput("rst_launch", bus.launch, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_valid", bus.valid, 0);
        checkOutput("rst_code", bus.code, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        measure("thermo16", 64'h0000_0000_0000_FFFF, 16, 1'b0, 1'b0);
        measure("allones",  {N{1'b1}},               64, 1'b1, 1'b0);
        measure("zeros",    64'h0,                   0,  1'b0, 1'b0);
        measure("bubble4",  64'h0000_0000_0000_00EF, 4,  1'b0, 1'b1);
        measure("topbub",   64'h8000_0000_0000_0007, 3,  1'b0, 1'b1);
        measure("code63",   64'h7FFF_FFFF_FFFF_FFFF, 63, 1'b0, 1'b0);

        // Consumer stalls; start is held high through DONE and RECOVER.
        applyStimulus(1'b1, 64'h3F, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 64'h3F, 1'b0);
        waitValid("stall", k);
        applyStimulus(1'b1, 64'h3F, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", bus.valid, 1);
            checkOutput("stall_code", bus.code, 6);
        end
        applyStimulus(1'b1, 64'h3F, 1'b1);
        @(negedge clk);
        checkOutput("stall_valid_drop", bus.valid, 0);
        applyStimulus(1'b1, 64'h3F, 1'b0);
        for (int i = 1; i <= RECOVER; i++) begin
            @(negedge clk);
            checkOutput("rec_launch", bus.launch, 0);
            checkOutput("rec_busy", bus.busy, (i < RECOVER) ? 1 : 0);
        end
        @(negedge clk);
        checkOutput("restart_launch", bus.launch, 1);
        applyStimulus(1'b0, 64'h3F, 1'b0);
        waitValid("restart", k);
        checkOutput("restart_code", bus.code, 6);
        applyStimulus(1'b0, 64'h3F, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 64'h3F, 1'b0);
        repeat (RECOVER) @(negedge clk);

        // Reset lands while the taps are in the second capture stage.
        applyStimulus(1'b1, 64'h0000_0000_0000_FFFF, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 64'h0000_0000_0000_FFFF, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_launch", bus.launch, 0);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_valid", bus.valid, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("postrst_valid", bus.valid, 0);
        end
        measure("afterrst", 64'h0000_0000_0000_00FF, 8, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
